// File: rtl/icache_fetch_assoc_pkg.sv
// Shared definitions for the set-associative instruction-fetch cache.
//   - default instruction address / word widths
//   - miss FSM state encoding
//   - clog2 helper used to derive the set index width
package icache_fetch_assoc_pkg;

  localparam int INSTRUCTION_ADDRESS_SIZE = 32;
  localparam int INSTRUCTION_SIZE         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } fsm_state_t;

  // Smallest r such that (1 << r) >= value; value 1 gives 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid bit, tag and instruction word.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears valid bits only)
//   inv_all    clear every valid bit at the clock edge
//   rd_idx/rd_tag -> hit, rdata   combinational lookup
//   wr_en, wr_idx, wr_tag, wr_data   synchronous line install (sets valid)
//   wr_valid   valid bit of the set addressed by wr_idx (victim selection)
module icache_way
  import icache_fetch_assoc_pkg::*;
#(
  parameter int INST_W = INSTRUCTION_SIZE,
  parameter int SETS   = 256,
  parameter int IDX_W  = 8,
  parameter int TAG_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inv_all,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic [INST_W-1:0] rdata,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [INST_W-1:0] wr_data,
  output logic              wr_valid
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [INST_W-1:0] data [SETS];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || inv_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays deliberately have no reset; the valid bits gate
  // every read, so this stays a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign hit      = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rdata    = data[rd_idx];
  assign wr_valid = valid[wr_idx];

endmodule

// File: rtl/icache_fetch_assoc.sv
// Instruction-fetch stage with an N-way (1 or 2) set-associative cache.
// Hits deliver pc/instruction combinationally; misses stall while a
// req/ack fetch to the memory controller refills the line.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pc                     fetch address from pc_reg
//   flush                  invalidate the whole cache
//   out_pc, out_inst       delivered pc / instruction (0 when stalled)
//   stall_flag             1 while pc misses, during FILL, or in reset
//   mem_req, mem_addr      refill request to mem_ctrl (held until mem_ack)
//   mem_ack, mem_rdata     one-cycle response pulse and returned word
module icache_fetch_assoc
  import icache_fetch_assoc_pkg::*;
#(
  parameter int ADDR_W = INSTRUCTION_ADDRESS_SIZE,
  parameter int INST_W = INSTRUCTION_SIZE,
  parameter int SETS   = 256,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              stall_flag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata
);

  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  fsm_state_t        state;
  logic [ADDR_W-1:0] miss_addr;
  logic [INST_W-1:0] fill_data;
  logic              discard;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [SETS-1:0]   lru;          // per set: way to evict next

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  logic [WAYS-1:0]   way_hit;
  logic [WAYS-1:0]   way_wr_valid;
  logic [WAYS-1:0]   fill_we;
  logic [INST_W-1:0] way_rdata [WAYS];

  logic              any_hit;
  logic              hit_way;
  logic [INST_W-1:0] hit_rdata;
  logic              victim;
  logic              lookup_hit;
  logic              unused_bits;

  assign idx      = pc[IDX_W+1:2];
  assign tag      = pc[ADDR_W-1:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[ADDR_W-1:IDX_W+2];

  assign unused_bits = ^{pc[1:0], miss_addr[1:0]};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    // Flush and reset both beat a pending FILL write.
    assign fill_we[w] = (state == FILL) && !flush && !rst && (victim == 1'(w));

    icache_way #(
      .INST_W (INST_W),
      .SETS   (SETS),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .inv_all  (flush),
      .rd_idx   (idx),
      .rd_tag   (tag),
      .hit      (way_hit[w]),
      .rdata    (way_rdata[w]),
      .wr_en    (fill_we[w]),
      .wr_idx   (fill_idx),
      .wr_tag   (fill_tag),
      .wr_data  (fill_data),
      .wr_valid (way_wr_valid[w])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    any_hit   = 1'b0;
    hit_way   = 1'b0;
    hit_rdata = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        any_hit   = 1'b1;
        hit_way   = 1'(w);
        hit_rdata = way_rdata[w];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the LRU bit names the victim.
  always_comb begin
    victim = (WAYS == 1) ? 1'b0 : lru[fill_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_wr_valid[w]) victim = 1'(w);
    end
  end

  assign lookup_hit = any_hit && (state != FILL) && !rst;
  assign out_pc     = lookup_hit ? pc : '0;
  assign out_inst   = lookup_hit ? hit_rdata : '0;
  assign stall_flag = !lookup_hit;
  assign mem_req    = mem_req_q && !rst;
  assign mem_addr   = rst ? '0 : mem_addr_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      lru <= '0;
    end else begin
      if (lookup_hit) lru[idx] <= ~hit_way;
      if (state == FILL) lru[fill_idx] <= ~victim;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      miss_addr  <= '0;
      fill_data  <= '0;
      discard    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!any_hit && !flush) begin
            miss_addr  <= {pc[ADDR_W-1:2], 2'b00};
            mem_addr_q <= {pc[ADDR_W-1:2], 2'b00};
            mem_req_q  <= 1'b1;
            discard    <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          // A flush seen at any point of the request drops the returned word.
          if (flush) discard <= 1'b1;
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            if (discard || flush) begin
              state <= IDLE;
            end else begin
              fill_data <= mem_rdata;
              state     <= FILL;
            end
          end
        end
        FILL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch_assoc.sv
// Self-checking bench for icache_fetch_assoc: directed scenarios plus random
// traffic on a 256-set 2-way instance checked against a recency-list cache
// model, and a directed check of a 4-set direct-mapped instance.
module tb_icache_fetch_assoc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 256-set, 2-way instance
  logic        rst, flush, mem_ack, stall_flag, mem_req;
  logic [31:0] pc, mem_rdata, out_pc, out_inst, mem_addr;

  // 4-set, 1-way instance
  logic        s_rst, s_flush, s_ack, s_stall, s_req;
  logic [31:0] s_pc, s_rdata, s_out_pc, s_out_inst, s_addr;

  int vectors = 0;
  int miscompares = 0;

  icache_fetch_assoc dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush),
    .out_pc(out_pc), .out_inst(out_inst), .stall_flag(stall_flag),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  icache_fetch_assoc #(.SETS(4), .WAYS(1)) dut_dm (
    .clk(clk), .rst(s_rst), .pc(s_pc), .flush(s_flush),
    .out_pc(s_out_pc), .out_inst(s_out_inst), .stall_flag(s_stall),
    .mem_req(s_req), .mem_addr(s_addr),
    .mem_ack(s_ack), .mem_rdata(s_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (2-way, 256 sets) ----------------
  // Each set is a list of resident lines ordered least- to most-recently used.
  logic [21:0] m_tag [256][2];
  logic [31:0] m_dat [256][2];
  int          m_cnt [256];
  int          m_phase;      // 0 idle, 1 waiting for memory, 2 writing line
  logic [31:0] m_addr, m_fdata;
  bit          m_discard;

  function automatic int m_find(input logic [31:0] a);
    int s;
    s = int'(a[9:2]);
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_tag[s][i] == a[31:10]) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 256; s++) m_cnt[s] = 0;
  endtask

  task automatic m_touch(input logic [31:0] a, input int pos);
    int s;
    logic [21:0] t;
    logic [31:0] d;
    s = int'(a[9:2]);
    t = m_tag[s][pos];
    d = m_dat[s][pos];
    for (int i = pos; i < m_cnt[s] - 1; i++) begin
      m_tag[s][i] = m_tag[s][i+1];
      m_dat[s][i] = m_dat[s][i+1];
    end
    m_tag[s][m_cnt[s]-1] = t;
    m_dat[s][m_cnt[s]-1] = d;
  endtask

  task automatic m_install(input logic [31:0] a, input logic [31:0] d);
    int s;
    s = int'(a[9:2]);
    if (m_cnt[s] == 2) begin
      m_tag[s][0] = m_tag[s][1];
      m_dat[s][0] = m_dat[s][1];
      m_cnt[s] = 1;
    end
    m_tag[s][m_cnt[s]] = a[31:10];
    m_dat[s][m_cnt[s]] = d;
    m_cnt[s]++;
  endtask

  // One clock cycle on the main instance: drive, compare, clock, update model.
  task automatic cyc(input logic [31:0] p, input bit fl, input bit ack,
                     input logic [31:0] rd, input bit r, input string tag);
    int pos;
    bit h;
    logic [31:0] inst_e;
    pc = p; flush = fl; mem_ack = ack; mem_rdata = rd; rst = r;
    #1;
    pos = m_find(p);
    h = !r && (m_phase != 2) && (pos >= 0);
    inst_e = h ? m_dat[int'(p[9:2])][pos] : 32'h0;
    check({tag, ".stall"},  32'(stall_flag), 32'(!h));
    check({tag, ".out_pc"}, out_pc, h ? p : 32'h0);
    check({tag, ".inst"},   out_inst, inst_e);
    check({tag, ".req"},    32'(mem_req), 32'(!r && m_phase == 1));
    check({tag, ".addr"},   mem_addr, (!r && m_phase == 1) ? m_addr : 32'h0);
    @(posedge clk);
    if (r) begin
      m_clear();
      m_phase = 0;
      m_discard = 0;
      m_addr = 0;
    end else begin
      if (h && !fl) m_touch(p, pos);
      if (fl) m_clear();
      case (m_phase)
        0: if (!h && !fl) begin
             m_addr = {p[31:2], 2'b00};
             m_discard = 0;
             m_phase = 1;
           end
        1: begin
             if (fl) m_discard = 1;
             if (ack) begin
               if (m_discard) m_phase = 0;
               else begin
                 m_fdata = rd;
                 m_phase = 2;
               end
             end
           end
        default: begin
             if (!fl) m_install(m_addr, m_fdata);
             m_phase = 0;
           end
      endcase
    end
    @(negedge clk);
  endtask

  // Miss on a, memory answers after lat wait cycles, then the hit cycle.
  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d,
                           input int lat, input string tag);
    cyc(a, 0, 0, 0, 0, {tag, ".idle"});
    for (int i = 0; i < lat; i++) cyc(a, 0, 0, 0, 0, {tag, ".wait"});
    cyc(a, 0, 1, d, 0, {tag, ".ack"});
    cyc(a, 0, 0, 0, 0, {tag, ".fill"});
    cyc(a, 0, 0, 0, 0, {tag, ".hit"});
  endtask

  // Direct-mapped instance: miss, immediate ack, fill, hit.
  task automatic sfill(input logic [31:0] a, input logic [31:0] d, input string tag);
    s_pc = a; s_ack = 1'b0; #1;
    check({tag, ".miss_stall"}, 32'(s_stall), 32'd1);
    check({tag, ".idle_req"},   32'(s_req), 32'd0);
    @(posedge clk); @(negedge clk);
    s_ack = 1'b1; s_rdata = d; #1;
    check({tag, ".req"},  32'(s_req), 32'd1);
    check({tag, ".addr"}, s_addr, a);
    @(posedge clk); @(negedge clk);
    s_ack = 1'b0; #1;
    check({tag, ".fill_stall"}, 32'(s_stall), 32'd1);
    check({tag, ".fill_req"},   32'(s_req), 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check({tag, ".hit_stall"}, 32'(s_stall), 32'd0);
    check({tag, ".hit_inst"},  s_out_inst, d);
    check({tag, ".hit_pc"},    s_out_pc, a);
  endtask

  logic [31:0] rp;
  bit          rfl, rack, rrst;

  initial begin
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; pc = '0;
    s_rst = 1'b1; s_flush = 1'b0; s_ack = 1'b0; s_rdata = '0; s_pc = '0;
    m_clear(); m_phase = 0; m_discard = 0; m_addr = 0; m_fdata = 0;
    @(negedge clk);

    // Reset outputs
    cyc(32'h100, 0, 0, 0, 1, "reset");
    cyc(32'h100, 0, 1, 32'hdead, 1, "reset2");

    // Cold miss, memory latency of 3 cycles after the request
    miss_fill(32'h100, 32'h00500093, 2, "cold");
    pc = 32'h100; #1;
    check("cold.inst_const", out_inst, 32'h00500093);
    check("cold.pc_const", out_pc, 32'h100);

    // Conflict in set 0x40: 0x900 must evict 0x500, not the touched 0x100
    miss_fill(32'h500, 32'h11110500, 1, "conf500");
    cyc(32'h100, 0, 0, 0, 0, "conf.touch100");
    miss_fill(32'h900, 32'h11110900, 1, "conf900");
    pc = 32'h100; #1;
    check("conf.100_stall", 32'(stall_flag), 32'd0);
    cyc(32'h100, 0, 0, 0, 0, "conf.hit100");
    pc = 32'h500; #1;
    check("conf.500_evicted", 32'(stall_flag), 32'd1);
    cyc(32'h500, 0, 0, 0, 0, "conf.miss500");
    cyc(32'h500, 0, 1, 32'h22220500, 0, "conf.ack500");
    cyc(32'h500, 0, 0, 0, 0, "conf.fill500");

    // Redirect during REQ: the fill for 0x200 still completes
    cyc(32'h200, 0, 0, 0, 0, "redir.miss200");
    pc = 32'h300; #1;
    check("redir.addr_held", mem_addr, 32'h200);
    cyc(32'h300, 0, 0, 0, 0, "redir.req");
    cyc(32'h300, 0, 1, 32'h33330200, 0, "redir.ack");
    cyc(32'h300, 0, 0, 0, 0, "redir.fill");
    cyc(32'h300, 0, 0, 0, 0, "redir.miss300");
    pc = 32'h300; #1;
    check("redir.addr300", mem_addr, 32'h300);
    cyc(32'h300, 0, 1, 32'h33330300, 0, "redir.ack300");
    cyc(32'h300, 0, 0, 0, 0, "redir.fill300");
    pc = 32'h200; #1;
    check("redir.hit200", out_inst, 32'h33330200);
    cyc(32'h200, 0, 0, 0, 0, "redir.hit200c");

    // Flush of a cached line
    miss_fill(32'h100, 32'h44440100, 0, "fl100");
    cyc(32'h100, 1, 0, 0, 0, "fl.pulse");
    pc = 32'h100; #1;
    check("fl.miss_after", 32'(stall_flag), 32'd1);
    cyc(32'h100, 0, 0, 0, 0, "fl.miss");
    cyc(32'h100, 0, 1, 32'h44440101, 0, "fl.ack");
    cyc(32'h100, 0, 0, 0, 0, "fl.fill");

    // Flush during REQ: returned data is discarded
    cyc(32'h400, 0, 0, 0, 0, "flreq.miss");
    cyc(32'h400, 1, 0, 0, 0, "flreq.flush");
    cyc(32'h400, 0, 1, 32'h55550400, 0, "flreq.ack");
    pc = 32'h400; #1;
    check("flreq.not_installed", 32'(stall_flag), 32'd1);
    miss_fill(32'h400, 32'h55550401, 0, "flreq.refill");

    // Reset in the middle of a request; stray ack afterwards is ignored
    cyc(32'h600, 0, 0, 0, 0, "rstreq.miss");
    cyc(32'h600, 0, 0, 0, 1, "rstreq.rst");
    pc = 32'h600; #1;
    check("rstreq.req_dropped", 32'(mem_req), 32'd0);
    cyc(32'h600, 0, 1, 32'h66660600, 0, "rstreq.stray");
    cyc(32'h400, 0, 0, 0, 0, "rstreq.lookup400");
    cyc(32'h100, 0, 1, 32'h66660601, 0, "rstreq.ack");
    cyc(32'h100, 0, 0, 0, 0, "rstreq.fill");

    // Random traffic over 8 lines in two sets
    rp = 32'h100;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0)
        rp = {20'h0, 2'($urandom_range(0, 3)), 7'h20, 1'($urandom_range(0, 1)), 2'b00};
      rfl  = ($urandom_range(0, 39) == 0);
      rrst = ($urandom_range(0, 99) == 0);
      rack = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      cyc(rp, rfl, rack, $urandom, rrst, "rand");
    end

    // Direct-mapped 4-set instance
    rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    sfill(32'h0,  32'hAAAA0000, "dm.0");
    sfill(32'h4,  32'hCCCC0004, "dm.4");
    sfill(32'h10, 32'hBBBB0010, "dm.10");
    s_pc = 32'h4; #1;
    check("dm.4_survives", s_out_inst, 32'hCCCC0004);
    s_pc = 32'h10; #1;
    check("dm.10_hit", s_out_inst, 32'hBBBB0010);
    s_pc = 32'h0; #1;
    check("dm.0_replaced", 32'(s_stall), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
